// File: rtl/branch_resolver_pkg.sv
// ---------------------------------------------------------------------------
// branch_resolver_pkg
// Shared branch-prediction definitions: resolver FSM state type, default
// sizing constants and a small width helper used by the resolver blocks.
// ---------------------------------------------------------------------------
package branch_resolver_pkg;

    localparam int DEFAULT_DEPTH        = 4;
    localparam int DEFAULT_CNT_W        = 16;
    localparam int DEFAULT_FLUSH_CYCLES = 2;

    // RUN: predictions flow normally. FLUSH: wrong-path state is discarded.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } resolver_state_e;

    // Width needed to count down from n-1 to 0; never narrower than one bit.
    function automatic int down_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : branch_resolver_pkg

// File: rtl/pred_fifo.sv
// ---------------------------------------------------------------------------
// pred_fifo
// In-order FIFO of one-bit predicted directions.
//   clk, reset_n     : clock, asynchronous active-low reset
//   push, push_data  : write one entry (ignored when full)
//   pop              : retire the oldest entry (ignored when empty)
//   clear            : discard every entry; wins over push and pop
//   pop_data         : oldest entry (valid when not empty)
//   full, empty      : occupancy flags
//   count            : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module pred_fifo
    import branch_resolver_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             push_data,
    input  logic             pop,
    input  logic             clear,
    output logic             pop_data,
    output logic             full,
    output logic             empty,
    output logic [OCC_W-1:0] count
);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == OCC_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
    // increment wraps modulo DEPTH on its own. The separate count keeps
    // full and empty distinguishable when the pointers are equal.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the storage is only DEPTH bits, so it is reset along with
            // the pointers; a wide RAM would normally be left unreset.
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : pred_fifo

// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
// Tracks in-flight branch predictions, compares each against the resolved
// outcome, trains the predictor, and flushes on a misprediction.
//   clk, reset_n           : clock, asynchronous active-low reset
//   pred_valid, pred_taken : prediction from the predictor
//   pred_ready             : prediction can be accepted (combinational)
//   res_valid, res_taken   : resolution of the oldest in-flight branch
//   upd_valid, upd_taken   : registered training update to the predictor
//   mispredict             : one-cycle pulse on a wrong prediction
//   flush                  : high FLUSH_CYCLES cycles after a misprediction
//   res_error              : one-cycle pulse on a resolve with nothing queued
//   hit_count, miss_count  : saturating prediction statistics
//   occupancy              : entries currently queued
// ---------------------------------------------------------------------------
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter  int DEPTH        = DEFAULT_DEPTH,
    parameter  int CNT_W        = DEFAULT_CNT_W,
    parameter  int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
    localparam int OCC_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pred_valid,
    input  logic             pred_taken,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             upd_valid,
    output logic             upd_taken,
    output logic             mispredict,
    output logic             flush,
    output logic             res_error,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [OCC_W-1:0] occupancy
);

    localparam int               FC_W    = down_cnt_width(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    resolver_state_e state;
    logic [FC_W-1:0] flush_cnt;

    logic in_run;
    logic fifo_full;
    logic fifo_empty;
    logic oldest_pred;
    logic do_push;
    logic do_pop;
    logic wrong;
    logic empty_resolve;

    assign in_run        = (state == ST_RUN);
    assign pred_ready    = in_run && !fifo_full;
    assign do_push       = pred_valid && pred_ready;
    assign do_pop        = res_valid && in_run && !fifo_empty;
    assign wrong         = do_pop && (res_taken != oldest_pred);
    assign empty_resolve = res_valid && in_run && fifo_empty;

    // A misprediction clears the queue; clear also drops a push accepted
    // in the same cycle, since that prediction lies on the wrong path.
    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (do_push),
        .push_data (pred_taken),
        .pop       (do_pop),
        .clear     (wrong),
        .pop_data  (oldest_pred),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_RUN;
            flush_cnt  <= '0;
            flush      <= 1'b0;
            mispredict <= 1'b0;
            res_error  <= 1'b0;
            upd_valid  <= 1'b0;
            upd_taken  <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            upd_valid  <= do_pop;
            mispredict <= wrong;
            res_error  <= empty_resolve;
            // upd_taken holds the last resolved outcome between updates.
            if (do_pop) begin
                upd_taken <= res_taken;
            end

            // flush_cnt counts the remaining FLUSH cycles after the current
            // one, so FLUSH lasts exactly FLUSH_CYCLES cycles.
            case (state)
                ST_RUN: begin
                    if (wrong) begin
                        state     <= ST_FLUSH;
                        flush     <= 1'b1;
                        flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= ST_RUN;
                        flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - FC_W'(1);
                    end
                end
                default: begin
                    state <= ST_RUN;
                    flush <= 1'b0;
                end
            endcase

            // Statistics saturate instead of wrapping.
            if (do_pop && !wrong && hit_count != CNT_MAX) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (wrong && miss_count != CNT_MAX) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

endmodule : branch_resolver

// File: tb/tb_branch_resolver.sv
// ---------------------------------------------------------------------------
// tb_branch_resolver
// Self-checking bench for branch_resolver: a directed vector table, short
// hand-written corner sequences, and random traffic compared against a
// queue-based reference model.
// ---------------------------------------------------------------------------
module tb_branch_resolver;
    import branch_resolver_pkg::*;

    localparam int DEPTH   = DEFAULT_DEPTH;
    localparam int CNT_W   = DEFAULT_CNT_W;
    localparam int FC      = DEFAULT_FLUSH_CYCLES;
    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset_n;
    logic             pred_valid;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             upd_valid;
    logic             upd_taken;
    logic             mispredict;
    logic             flush;
    logic             res_error;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;
    logic [OCC_W-1:0] occupancy;

    branch_resolver #(
        .DEPTH        (DEPTH),
        .CNT_W        (CNT_W),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_ready (pred_ready),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .upd_valid  (upd_valid),
        .upd_taken  (upd_taken),
        .mispredict (mispredict),
        .flush      (flush),
        .res_error  (res_error),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a queue of predicted directions plus plain counters.
    bit mq[$];
    int m_hits;
    int m_misses;
    int m_flush_left;
    bit m_uv, m_ut, m_mis, m_err;
    bit m_ready_seen;
    logic dut_ready_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit model_ready();
        return (m_flush_left == 0) && (mq.size() < DEPTH);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_hits = 0; m_misses = 0; m_flush_left = 0;
        m_uv = 0; m_ut = 0; m_mis = 0; m_err = 0;
    endtask

    task automatic model_step(input bit pv, input bit pt, input bit rv, input bit rt);
        bit run, push_ok, pop_ok, wrong;
        run     = (m_flush_left == 0);
        push_ok = pv && run && (mq.size() < DEPTH);
        pop_ok  = rv && run && (mq.size() > 0);
        wrong   = pop_ok && (mq[0] != rt);
        m_err   = rv && run && (mq.size() == 0);
        m_uv    = pop_ok;
        if (pop_ok) m_ut = rt;
        m_mis   = wrong;
        if (m_flush_left > 0) m_flush_left--;
        if (wrong) begin
            mq.delete();
            if (m_misses < CNT_MAX) m_misses++;
            m_flush_left = FC;
        end else begin
            if (pop_ok) begin
                void'(mq.pop_front());
                if (m_hits < CNT_MAX) m_hits++;
            end
            if (push_ok) mq.push_back(pt);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, sample pred_ready
    // before the rising edge, advance the model, then settle past the edge.
    task automatic apply(input bit pv, input bit pt, input bit rv, input bit rt);
        @(negedge clk);
        pred_valid = pv; pred_taken = pt; res_valid = rv; res_taken = rt;
        #1;
        dut_ready_seen = pred_ready;
        m_ready_seen   = model_ready();
        model_step(pv, pt, rv, rt);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " pred_ready"}, 32'(dut_ready_seen), 32'(m_ready_seen));
        check({tag, " upd_valid"},  32'(upd_valid),  32'(m_uv));
        if (m_uv) check({tag, " upd_taken"}, 32'(upd_taken), 32'(m_ut));
        check({tag, " mispredict"}, 32'(mispredict), 32'(m_mis));
        check({tag, " flush"},      32'(flush),      32'(m_flush_left > 0));
        check({tag, " res_error"},  32'(res_error),  32'(m_err));
        check({tag, " occupancy"},  32'(occupancy),  32'(mq.size()));
        check({tag, " hit_count"},  32'(hit_count),  32'(m_hits));
        check({tag, " miss_count"}, 32'(miss_count), 32'(m_misses));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        pred_valid = 0; pred_taken = 0; res_valid = 0; res_taken = 0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit pv, pt, rv, rt;
        bit ready;
        bit uv, ut, mis, fl, err;
        int occ, hit, miss;
    } vec_t;

    vec_t vecs[15];

    initial begin
        reset_n = 1'b0;
        pred_valid = 0; pred_taken = 0; res_valid = 0; res_taken = 0;
        model_reset();
        #12;
        // Reset state, checked while reset is still asserted.
        check("reset occupancy",  32'(occupancy), 0);
        check("reset hit_count",  32'(hit_count), 0);
        check("reset upd_valid",  32'(upd_valid), 0);
        check("reset flush",      32'(flush), 0);
        check("reset pred_ready", 32'(pred_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;

        // Three correct resolves, then a mispredict with flush, ignored
        // resolve and dropped push during flush, and recovery.
        //           pv pt rv rt rdy uv ut mi fl er occ hit miss
        vecs[0]  = '{1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0, 0};
        vecs[1]  = '{1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 2, 0, 0};
        vecs[2]  = '{1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3, 0, 0};
        vecs[3]  = '{0, 0, 1, 1, 1,  1, 1, 0, 0, 0, 2, 1, 0};
        vecs[4]  = '{0, 0, 1, 1, 1,  1, 1, 0, 0, 0, 1, 2, 0};
        vecs[5]  = '{0, 0, 1, 0, 1,  1, 0, 0, 0, 0, 0, 3, 0};
        vecs[6]  = '{0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 3, 0};
        vecs[7]  = '{1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 1, 3, 0};
        vecs[8]  = '{1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 3, 0};
        vecs[9]  = '{1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 3, 3, 0};
        vecs[10] = '{0, 0, 1, 0, 1,  1, 0, 1, 1, 0, 0, 3, 1};
        vecs[11] = '{1, 1, 1, 1, 0,  0, 0, 0, 1, 0, 0, 3, 1};
        vecs[12] = '{1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 3, 1};
        vecs[13] = '{1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 1, 3, 1};
        vecs[14] = '{0, 0, 1, 1, 1,  1, 1, 0, 0, 0, 0, 4, 1};

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].pv, vecs[i].pt, vecs[i].rv, vecs[i].rt);
            check($sformatf("vec%0d pred_ready", i), 32'(dut_ready_seen), 32'(vecs[i].ready));
            check($sformatf("vec%0d upd_valid", i),  32'(upd_valid),  32'(vecs[i].uv));
            check($sformatf("vec%0d upd_taken", i),  32'(upd_taken),  32'(vecs[i].ut));
            check($sformatf("vec%0d mispredict", i), 32'(mispredict), 32'(vecs[i].mis));
            check($sformatf("vec%0d flush", i),      32'(flush),      32'(vecs[i].fl));
            check($sformatf("vec%0d res_error", i),  32'(res_error),  32'(vecs[i].err));
            check($sformatf("vec%0d occupancy", i),  32'(occupancy),  vecs[i].occ);
            check($sformatf("vec%0d hit_count", i),  32'(hit_count),  vecs[i].hit);
            check($sformatf("vec%0d miss_count", i), 32'(miss_count), vecs[i].miss);
        end

        // Fill to DEPTH, drop a fifth push, drain, then reuse the wrapped slots.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            apply(1, i[0], 0, 0);
            check_model($sformatf("fill%0d", i));
        end
        check("full occupancy", 32'(occupancy), DEPTH);
        check("full pred_ready", 32'(pred_ready), 0);
        apply(1, 1, 0, 0);
        check_model("drop push");
        for (int i = 0; i < DEPTH; i++) begin
            apply(0, 0, 1, i[0]);
            check_model($sformatf("drain%0d", i));
        end
        check("drain hit_count", 32'(hit_count), DEPTH);
        apply(1, 1, 0, 0);
        apply(1, 0, 0, 0);
        apply(0, 0, 1, 1);
        check_model("wrap pop0");
        apply(0, 0, 1, 0);
        check_model("wrap pop1");
        check("wrap hit_count", 32'(hit_count), DEPTH + 2);

        // Simultaneous push and correct pop at occupancy 2; then empty resolve.
        do_reset();
        apply(1, 1, 0, 0);
        apply(1, 0, 0, 0);
        apply(1, 1, 1, 1);
        check_model("push+pop");
        check("push+pop occupancy", 32'(occupancy), 2);
        apply(0, 0, 1, 0);
        apply(0, 0, 1, 1);
        apply(0, 0, 1, 1);
        check_model("empty resolve");
        check("empty res_error", 32'(res_error), 1);
        check("empty hit_count", 32'(hit_count), 3);
        check("empty miss_count", 32'(miss_count), 0);
        apply(0, 0, 0, 0);
        check_model("error clears");

        // Reset in the middle of a flush clears everything immediately.
        do_reset();
        apply(1, 1, 0, 0);
        apply(0, 0, 1, 0);
        check_model("pre-reset mispredict");
        #2;
        reset_n = 1'b0;
        #1;
        check("rst flush",      32'(flush), 0);
        check("rst mispredict", 32'(mispredict), 0);
        check("rst upd_valid",  32'(upd_valid), 0);
        check("rst upd_taken",  32'(upd_taken), 0);
        check("rst res_error",  32'(res_error), 0);
        check("rst miss_count", 32'(miss_count), 0);
        check("rst hit_count",  32'(hit_count), 0);
        check("rst occupancy",  32'(occupancy), 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        #1;
        check("post-rst pred_ready", 32'(pred_ready), 1);
        apply(1, 0, 0, 0);
        check_model("post-rst push");

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            apply(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            check_model($sformatf("rand%0d", i));
        end

        // Hit counter saturation: a steady push+correct-pop stream.
        do_reset();
        apply(1, 1, 0, 0);
        for (int i = 0; i < CNT_MAX; i++) begin
            apply(1, 1, 1, 1);
        end
        check("sat reach hit_count", 32'(hit_count), CNT_MAX);
        apply(1, 1, 1, 1);
        check_model("sat extra");
        check("sat hold hit_count", 32'(hit_count), CNT_MAX);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_branch_resolver
